// File: rtl/grey_pkg.sv
// Shared constants and types for the grey counter controller.
//   DIGITS     : number of counter digits scanned
//   DW         : bits per digit
//   INIT_W     : width of the preset word (DIGITS*DW)
//   BIT_CNT_W  : width of the serial-load bit counter
//   SEL_W      : width of the digit-select bus
//   state_t    : load FSM states
package grey_pkg;

    localparam int unsigned DIGITS    = 12;
    localparam int unsigned DW        = 5;
    localparam int unsigned INIT_W    = DIGITS * DW;
    localparam int unsigned BIT_CNT_W = 6;
    localparam int unsigned SEL_W     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        APPLY = 2'd2
    } state_t;

endpackage

// File: rtl/grey_ctrl_if.sv
// Control/datapath bundle for grey_ctrl.
//   master : drives the i_* requests, observes the o_* results (bench / host)
//   slave  : the controller itself
//   i_load, i_sdata, i_run, i_manual, i_sel : load, serial data, run, scan mode, manual digit
//   o_init, o_load, o_cnt_en, o_sel, o_strobe, o_busy : preset, load strobe, enable, digit scan
interface grey_ctrl_if;
    import grey_pkg::*;

    logic              i_load;
    logic              i_sdata;
    logic              i_run;
    logic              i_manual;
    logic [SEL_W-1:0]  i_sel;
    logic [INIT_W-1:0] o_init;
    logic              o_load;
    logic              o_cnt_en;
    logic [SEL_W-1:0]  o_sel;
    logic              o_strobe;
    logic              o_busy;

    modport master (
        output i_load, i_sdata, i_run, i_manual, i_sel,
        input  o_init, o_load, o_cnt_en, o_sel, o_strobe, o_busy
    );

    modport slave (
        input  i_load, i_sdata, i_run, i_manual, i_sel,
        output o_init, o_load, o_cnt_en, o_sel, o_strobe, o_busy
    );

endinterface

// File: rtl/grey_scan.sv
// Digit-select generator for the multiplexed display.
//   i_clk, i_rst : clock, async active-high reset
//   i_manual     : 1 = follow i_sel (clamped), 0 = auto scan every SCAN_DIV clocks
//   i_sel        : manual digit request
//   o_sel        : registered digit select
//   o_strobe     : one-cycle pulse whenever o_sel changes
module grey_scan
    import grey_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_manual,
    input  logic [SEL_W-1:0] i_sel,
    output logic [SEL_W-1:0] o_sel,
    output logic             o_strobe
);

    localparam int unsigned      DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(DIGITS - 1);

    logic [DIV_W-1:0] div;
    logic [SEL_W-1:0] sel_clamp;

    always_comb begin
        sel_clamp = (i_sel > SEL_LAST) ? SEL_LAST : i_sel;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            div      <= '0;
            o_sel    <= '0;
            o_strobe <= 1'b0;
        end else if (i_manual) begin
            // divider parked at 0 so auto scan resumes with a full dwell
            div      <= '0;
            o_sel    <= sel_clamp;
            o_strobe <= (sel_clamp != o_sel);
        end else if (div == DIV_LAST) begin
            div      <= '0;
            o_sel    <= (o_sel == SEL_LAST) ? '0 : o_sel + 8'd1;
            o_strobe <= 1'b1;
        end else begin
            div      <= div + 1'b1;
            o_strobe <= 1'b0;
        end
    end

endmodule

// File: rtl/grey_ctrl.sv
// Sequencer for the 12-digit grey counter datapath: serial preset load,
// one-cycle apply strobe, run gating and display digit scan.
//   i_clk, i_rst : clock, async active-high reset
//   bus (slave)  : i_load/i_sdata serial preset, i_run, i_manual/i_sel scan control;
//                  o_init/o_load preset, o_cnt_en, o_sel/o_strobe scan, o_busy
module grey_ctrl
    import grey_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    grey_ctrl_if.slave  bus
);

    state_t                 state;
    logic [INIT_W-1:0]      shreg;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [INIT_W-1:0]      init_q;
    logic                   load_q;
    logic                   cnt_en_q;
    logic                   busy_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            init_q   <= '0;
            load_q   <= 1'b0;
            cnt_en_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            load_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_load) begin
                        state    <= SHIFT;
                        busy_q   <= 1'b1;
                        cnt_en_q <= 1'b0;
                        bit_cnt  <= '0;
                    end else begin
                        cnt_en_q <= bus.i_run;
                    end
                end
                SHIFT: begin
                    cnt_en_q <= 1'b0;
                    // all 60 bits are shifted before the count reaches INIT_W;
                    // the terminal count cycle only hands over to APPLY
                    if (bit_cnt == BIT_CNT_W'(INIT_W)) begin
                        state <= APPLY;
                    end else begin
                        shreg   <= {shreg[INIT_W-2:0], bus.i_sdata};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                APPLY: begin
                    init_q   <= shreg;
                    load_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    cnt_en_q <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_init   = init_q;
    assign bus.o_load   = load_q;
    assign bus.o_cnt_en = cnt_en_q;
    assign bus.o_busy   = busy_q;

    grey_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_manual (bus.i_manual),
        .i_sel    (bus.i_sel),
        .o_sel    (bus.o_sel),
        .o_strobe (bus.o_strobe)
    );

endmodule

// File: tb/tb_grey_ctrl.sv
module tb_grey_ctrl;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    logic [59:0] sb_init [$];
    logic [7:0]  sb_sel  [$];

    grey_ctrl_if bus ();

    grey_ctrl #(
        .SCAN_DIV (4)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.i_run = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (bus.o_cnt_en !== 1'b1) begin
            n_bad++; $display("FAIL pre_rst_cnt_en: got %0b expected 1", bus.o_cnt_en);
        end
        n_cmp++;
        if (bus.o_sel !== 8'd2) begin
            n_bad++; $display("FAIL pre_rst_sel: got %0d expected 2", bus.o_sel);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.o_init, bus.o_load, bus.o_cnt_en, bus.o_sel, bus.o_strobe, bus.o_busy} !== '0) begin
            n_bad++;
            $display("FAIL async_reset: got init=%0h load=%0b en=%0b sel=%0d strobe=%0b busy=%0b expected all 0",
                     bus.o_init, bus.o_load, bus.o_cnt_en, bus.o_sel, bus.o_strobe, bus.o_busy);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.o_cnt_en !== 1'b1) begin
            n_bad++; $display("FAIL post_rst_cnt_en: got %0b expected 1", bus.o_cnt_en);
        end
        n_cmp++;
        if (bus.o_sel !== 8'd0 || bus.o_strobe !== 1'b0) begin
            n_bad++; $display("FAIL post_rst_sel: got sel=%0d strobe=%0b expected 0/0", bus.o_sel, bus.o_strobe);
        end
    endtask

    task automatic test_load;
        logic [59:0] v;
        logic [59:0] init_before;
        v = 60'h123_4567_89AB_CDEF;
        sb_init.push_back(v);
        init_before = bus.o_init;
        bus.i_run  = 1'b1;
        bus.i_load = 1'b1;
        @(negedge clk);
        bus.i_load = 1'b0;
        for (int c = 0; c <= 63; c++) begin
            n_cmp++;
            if (bus.o_busy !== (c <= 61)) begin
                n_bad++; $display("FAIL load_busy c=%0d: got %0b expected %0b", c, bus.o_busy, (c <= 61));
            end
            n_cmp++;
            if (bus.o_cnt_en !== (c == 63)) begin
                n_bad++; $display("FAIL load_cnt_en c=%0d: got %0b expected %0b", c, bus.o_cnt_en, (c == 63));
            end
            n_cmp++;
            if (bus.o_load !== (c == 62)) begin
                n_bad++; $display("FAIL load_strobe c=%0d: got %0b expected %0b", c, bus.o_load, (c == 62));
            end
            if (bus.o_load === 1'b1) begin
                n_cmp++;
                if (sb_init.size() == 0) begin
                    n_bad++; $display("FAIL load_init: got %0h with nothing expected", bus.o_init);
                end else begin
                    logic [59:0] e;
                    e = sb_init.pop_front();
                    if (bus.o_init !== e) begin
                        n_bad++; $display("FAIL load_init: got %0h expected %0h", bus.o_init, e);
                    end
                end
            end else if (c < 62) begin
                n_cmp++;
                if (bus.o_init !== init_before) begin
                    n_bad++; $display("FAIL load_init_hold c=%0d: got %0h expected %0h", c, bus.o_init, init_before);
                end
            end
            bus.i_sdata = (c < 60) ? v[59-c] : 1'b0;
            @(negedge clk);
        end
        n_cmp++;
        if (sb_init.size() != 0) begin
            n_bad++; $display("FAIL load_pending: got %0d queued expected 0", sb_init.size());
            sb_init.delete();
        end
    endtask

    task automatic test_auto_scan;
        logic [63:0] r;
        logic [59:0] v;
        logic        synced;
        int          gap;
        int          steps;
        bus.i_manual = 1'b0;
        bus.i_run    = 1'b0;
        synced = 1'b0;
        for (int i = 0; i < 12 && !synced; i++) begin
            @(negedge clk);
            if (bus.o_strobe === 1'b1) synced = 1'b1;
        end
        n_cmp++;
        if (synced !== 1'b1) begin
            n_bad++; $display("FAIL scan_sync: got no strobe expected one within 12 clocks");
        end
        for (int i = 1; i <= 17; i++) sb_sel.push_back(8'((int'(bus.o_sel) + i) % 12));
        r = {$urandom(), $urandom()};
        v = r[59:0];
        sb_init.push_back(v);
        bus.i_load = 1'b1;
        gap   = 0;
        steps = 0;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            bus.i_load  = 1'b0;
            bus.i_sdata = (c < 60) ? v[59-c] : 1'b0;
            gap++;
            if (bus.o_strobe === 1'b1) begin
                n_cmp++;
                if (gap != 4) begin
                    n_bad++; $display("FAIL scan_gap: got %0d clocks expected 4", gap);
                end
                n_cmp++;
                if (sb_sel.size() == 0) begin
                    n_bad++; $display("FAIL scan_sel: got %0d with nothing expected", bus.o_sel);
                end else begin
                    logic [7:0] e;
                    e = sb_sel.pop_front();
                    if (bus.o_sel !== e) begin
                        n_bad++; $display("FAIL scan_sel: got %0d expected %0d", bus.o_sel, e);
                    end
                end
                gap = 0;
                steps++;
            end
            if (bus.o_load === 1'b1) begin
                n_cmp++;
                if (c != 62) begin
                    n_bad++; $display("FAIL scan_load_time: got c=%0d expected 62", c);
                end
                n_cmp++;
                if (sb_init.size() == 0) begin
                    n_bad++; $display("FAIL scan_load_init: got %0h with nothing expected", bus.o_init);
                end else begin
                    logic [59:0] e;
                    e = sb_init.pop_front();
                    if (bus.o_init !== e) begin
                        n_bad++; $display("FAIL scan_load_init: got %0h expected %0h", bus.o_init, e);
                    end
                end
            end
        end
        n_cmp++;
        if (steps != 17 || sb_sel.size() != 0 || sb_init.size() != 0) begin
            n_bad++; $display("FAIL scan_count: got steps=%0d sel_left=%0d init_left=%0d expected 17/0/0",
                              steps, sb_sel.size(), sb_init.size());
            sb_sel.delete();
            sb_init.delete();
        end
    endtask

    task automatic test_reset_mid_load;
        logic [59:0] v;
        logic        seen;
        bus.i_run  = 1'b1;
        bus.i_load = 1'b1;
        @(negedge clk);
        bus.i_load = 1'b0;
        for (int c = 0; c < 30; c++) begin
            bus.i_sdata = 1'($urandom());
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.o_init !== 60'd0 || bus.o_busy !== 1'b0) begin
            n_bad++; $display("FAIL midload_rst: got init=%0h busy=%0b expected 0/0", bus.o_init, bus.o_busy);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            bus.i_sdata = 1'($urandom());
            @(negedge clk);
        end
        n_cmp++;
        if (bus.o_cnt_en !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_init !== 60'd0) begin
            n_bad++; $display("FAIL midload_idle: got en=%0b busy=%0b init=%0h expected 1/0/0",
                              bus.o_cnt_en, bus.o_busy, bus.o_init);
        end
        v = 60'hFFF_FFFF_FFFF_FFFF;
        sb_init.push_back(v);
        bus.i_load = 1'b1;
        @(negedge clk);
        bus.i_load = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 70 && !seen; c++) begin
            if (bus.o_load === 1'b1) begin
                seen = 1'b1;
                n_cmp++;
                if (c != 62) begin
                    n_bad++; $display("FAIL reload_time: got c=%0d expected 62", c);
                end
                n_cmp++;
                if (sb_init.size() == 0) begin
                    n_bad++; $display("FAIL reload_init: got %0h with nothing expected", bus.o_init);
                end else begin
                    logic [59:0] e;
                    e = sb_init.pop_front();
                    if (bus.o_init !== e) begin
                        n_bad++; $display("FAIL reload_init: got %0h expected %0h", bus.o_init, e);
                    end
                end
            end
            bus.i_sdata = (c < 60) ? v[59-c] : 1'b0;
            @(negedge clk);
        end
        n_cmp++;
        if (!seen) begin
            n_bad++; $display("FAIL reload_timeout: got no o_load expected one within 70 clocks");
            sb_init.delete();
        end
    endtask

    task automatic test_manual;
        bus.i_manual = 1'b1;
        bus.i_sel    = 8'd2;
        repeat (2) @(negedge clk);
        sb_sel.push_back(8'd7);
        bus.i_sel = 8'd7;
        @(negedge clk);
        n_cmp++;
        if (bus.o_strobe !== 1'b1) begin
            n_bad++; $display("FAIL manual_strobe7: got %0b expected 1", bus.o_strobe);
        end else begin
            logic [7:0] e;
            e = sb_sel.pop_front();
            n_cmp++;
            if (bus.o_sel !== e) begin
                n_bad++; $display("FAIL manual_sel7: got %0d expected %0d", bus.o_sel, e);
            end
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.o_sel !== 8'd7 || bus.o_strobe !== 1'b0) begin
                n_bad++; $display("FAIL manual_hold c=%0d: got sel=%0d strobe=%0b expected 7/0", c, bus.o_sel, bus.o_strobe);
            end
        end
        bus.i_sel = 8'd200;
        @(negedge clk);
        n_cmp++;
        if (bus.o_sel !== 8'd11 || bus.o_strobe !== 1'b1) begin
            n_bad++; $display("FAIL manual_clamp: got sel=%0d strobe=%0b expected 11/1", bus.o_sel, bus.o_strobe);
        end
        bus.i_manual = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.o_sel !== ((c == 4) ? 8'd0 : 8'd11) || bus.o_strobe !== (c == 4)) begin
                n_bad++; $display("FAIL manual_resume c=%0d: got sel=%0d strobe=%0b expected %0d/%0b",
                                  c, bus.o_sel, bus.o_strobe, (c == 4) ? 0 : 11, (c == 4));
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [59:0] v1;
        logic [59:0] v2;
        int          loads;
        v1 = 60'hA5A_5A5A_5A5A_5A5A;
        v2 = 60'h0F0_F0F0_F0F0_F0F1;
        sb_init.push_back(v1);
        sb_init.push_back(v2);
        bus.i_run  = 1'b1;
        bus.i_load = 1'b1;
        loads = 0;
        @(negedge clk);
        for (int c = 0; c <= 126; c++) begin
            n_cmp++;
            if (bus.o_busy !== ((c <= 61) || (c >= 63 && c <= 124))) begin
                n_bad++; $display("FAIL b2b_busy c=%0d: got %0b", c, bus.o_busy);
            end
            n_cmp++;
            if (bus.o_cnt_en !== (c == 126)) begin
                n_bad++; $display("FAIL b2b_cnt_en c=%0d: got %0b expected %0b", c, bus.o_cnt_en, (c == 126));
            end
            n_cmp++;
            if (bus.o_load !== (c == 62 || c == 125)) begin
                n_bad++; $display("FAIL b2b_load c=%0d: got %0b expected %0b", c, bus.o_load, (c == 62 || c == 125));
            end
            if (bus.o_load === 1'b1) begin
                loads++;
                n_cmp++;
                if (sb_init.size() == 0) begin
                    n_bad++; $display("FAIL b2b_init: got %0h with nothing expected", bus.o_init);
                end else begin
                    logic [59:0] e;
                    e = sb_init.pop_front();
                    if (bus.o_init !== e) begin
                        n_bad++; $display("FAIL b2b_init: got %0h expected %0h", bus.o_init, e);
                    end
                end
            end
            if (c == 63) bus.i_load = 1'b0;
            if (c < 60)                  bus.i_sdata = v1[59-c];
            else if (c >= 63 && c < 123) bus.i_sdata = v2[59-(c-63)];
            else                         bus.i_sdata = 1'b0;
            @(negedge clk);
        end
        n_cmp++;
        if (loads != 2 || sb_init.size() != 0) begin
            n_bad++; $display("FAIL b2b_count: got loads=%0d left=%0d expected 2/0", loads, sb_init.size());
            sb_init.delete();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst          = 1'b1;
        bus.i_load   = 1'b0;
        bus.i_sdata  = 1'b0;
        bus.i_run    = 1'b0;
        bus.i_manual = 1'b0;
        bus.i_sel    = 8'd0;

        test_reset();
        test_load();
        test_auto_scan();
        test_reset_mid_load();
        test_manual();
        test_back_to_back();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
